iir_allpole_inv: RTL

//  Recursive all-pole IIR that undoes a streaming FIR (deconvolution/equaliser stage).

---
 rtl/filt_pkg.sv | 51 +++++
 rtl/iir_allpole_inv_mac_unit.sv | 53 +++++
 rtl/iir_allpole_inv.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/filt_pkg.sv
// Shared filter-chain definitions: IIR state encoding, signed saturation
// helper (also used by the FIR saturation stage) and accumulator sizing rule.
package filt_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MAC   = 2'd1,
        ROUND = 2'd2,
        OUT   = 2'd3
    } iir_state_e;

    // Widest value the saturation helper can take in.
    localparam int SAT_W = 64;

    typedef struct packed {
        logic                    ovf;
        logic signed [SAT_W-1:0] val;
    } sat_res_t;

    // Clip a signed value into a signed 'width'-bit range; ovf flags a clip.
    function automatic sat_res_t sat_signed(input logic signed [SAT_W-1:0] value,
                                            input int unsigned             width);
        logic signed [SAT_W-1:0] max_v;
        logic signed [SAT_W-1:0] min_v;
        sat_res_t                res;
        max_v = (64'sd1 <<< (width - 32'd1)) - 64'sd1;
        min_v = -(64'sd1 <<< (width - 32'd1));
        if (value > max_v) begin
            res.val = max_v;
            res.ovf = 1'b1;
        end else if (value < min_v) begin
            res.val = min_v;
            res.ovf = 1'b1;
        end else begin
            res.val = value;
            res.ovf = 1'b0;
        end
        return res;
    endfunction

    // Smallest accumulator that holds the scaled input and a full product sum.
    function automatic int ACC_MIN_W(input int in_w, input int frac, input int coef_w,
                                     input int out_w, input int order);
        int load_w;
        int sum_w;
        load_w = in_w + frac + 1;
        sum_w  = coef_w + out_w + $clog2(order) + 1;
        return (load_w > sum_w) ? load_w : sum_w;
    endfunction

endpackage

// File: rtl/iir_allpole_inv_mac_unit.sv
// Registered accumulator for the all-pole IIR: loads the scaled input sample,
// then subtracts one coefficient * history product per enabled cycle.
module iir_mac_unit #(
    parameter int IN_WIDTH   = 10,
    parameter int OUT_WIDTH  = 6,
    parameter int COEF_WIDTH = 8,
    parameter int FRAC_BITS  = 4,
    parameter int ACC_WIDTH  = 24
) (
    input  logic                        clk,
    input  logic                        rst_b,
    input  logic                        load_i,
    input  logic                        mac_i,
    input  logic [IN_WIDTH-1:0]         data_i,
    input  logic [COEF_WIDTH-1:0]       coef_i,
    input  logic [OUT_WIDTH-1:0]        hist_i,
    output logic signed [ACC_WIDTH-1:0] acc_o
);

    localparam int PW = COEF_WIDTH + OUT_WIDTH;

    logic signed [ACC_WIDTH-1:0] acc_q, acc_d;
    logic signed [ACC_WIDTH-1:0] load_val_s;
    logic signed [PW-1:0]        prod_s;

    // Input aligned to the coefficient fixed point; product at full precision.
    assign load_val_s = ACC_WIDTH'($signed(data_i)) <<< FRAC_BITS;
    assign prod_s     = PW'($signed(coef_i)) * PW'($signed(hist_i));

    // Next accumulator value: load wins over a tap, otherwise hold.
    always_comb begin
        acc_d = acc_q;
        if (load_i) begin
            acc_d = load_val_s;
        end else if (mac_i) begin
            acc_d = acc_q - ACC_WIDTH'(prod_s);
        end else begin
            acc_d = acc_q;
        end
    end

    // Accumulator register.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign acc_o = acc_q;

endmodule

// File: rtl/iir_allpole_inv.sv
// All-pole recursive IIR y[n] = x[n] - sum a_k*y[n-k] undoing an upstream FIR.
// One shared MAC walks the taps; the history holds saturated outputs so the
// recursion sees exactly what left the block.
module iir_allpole_inv
    import filt_pkg::*;
#(
    parameter int                            IN_WIDTH   = 10,
    parameter int                            OUT_WIDTH  = 6,
    parameter int                            ORDER      = 4,
    parameter int                            COEF_WIDTH = 8,
    parameter int                            FRAC_BITS  = 4,
    parameter int                            ACC_WIDTH  = 24,
    parameter logic [ORDER*COEF_WIDTH-1:0]   COEFS      = '0
) (
    input  logic                 clk,
    input  logic                 rst_b,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [IN_WIDTH-1:0]  data_in,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [OUT_WIDTH-1:0] data_out,
    output logic                 sat_flag,
    input  logic                 sat_clear
);

    localparam int KW = (ORDER > 1) ? $clog2(ORDER) : 1;
    localparam logic signed [ACC_WIDTH-1:0] RND_C = ACC_WIDTH'((1 << FRAC_BITS) >> 1);

    if ((ORDER < 1) || (ACC_WIDTH > SAT_W) ||
        (ACC_WIDTH < ACC_MIN_W(IN_WIDTH, FRAC_BITS, COEF_WIDTH, OUT_WIDTH, ORDER))) begin : g_param_chk
        $error("iir_allpole_inv: ORDER must be >= 1 and ACC_WIDTH wide enough (and <= 64)");
    end

    iir_state_e                  state_q, state_d;
    logic [KW-1:0]               k_q, k_d;
    logic signed [OUT_WIDTH-1:0] hist_q [ORDER];
    logic signed [OUT_WIDTH-1:0] hist_d [ORDER];
    logic signed [OUT_WIDTH-1:0] dout_q, dout_d;
    logic                        oval_q, oval_d;
    logic                        sat_q, sat_d;

    logic                        mac_load_s, mac_en_s, hist_shift_s, hist_clr_s, sat_set_s;
    logic signed [ACC_WIDTH-1:0] acc_s, rnd_s, r_s;
    logic [COEF_WIDTH-1:0]       coef_s;
    logic [OUT_WIDTH-1:0]        hist_tap_s;
    logic signed [OUT_WIDTH-1:0] sat_val_s;
    sat_res_t                    sat_res_s;
    logic                        sat_hi_unused_s;

    iir_mac_unit #(
        .IN_WIDTH   (IN_WIDTH),
        .OUT_WIDTH  (OUT_WIDTH),
        .COEF_WIDTH (COEF_WIDTH),
        .FRAC_BITS  (FRAC_BITS),
        .ACC_WIDTH  (ACC_WIDTH)
    ) u_mac (
        .clk    (clk),
        .rst_b  (rst_b),
        .load_i (mac_load_s),
        .mac_i  (mac_en_s),
        .data_i (data_in),
        .coef_i (coef_s),
        .hist_i (hist_tap_s),
        .acc_o  (acc_s)
    );

    // Select coefficient a_{k+1} and history y[n-1-k] for the current tap.
    always_comb begin
        coef_s     = '0;
        hist_tap_s = '0;
        for (int i = 0; i < ORDER; i++) begin
            if (k_q == KW'(i)) begin
                coef_s     = COEFS[i*COEF_WIDTH +: COEF_WIDTH];
                hist_tap_s = hist_q[i];
            end else begin
                coef_s     = coef_s;
                hist_tap_s = hist_tap_s;
            end
        end
    end

    // Round half up at the binary point, then clip to the output range.
    assign rnd_s           = acc_s + RND_C;
    assign r_s             = rnd_s >>> FRAC_BITS;
    assign sat_res_s       = sat_signed(SAT_W'(r_s), OUT_WIDTH);
    assign sat_val_s       = sat_res_s.val[OUT_WIDTH-1:0];
    assign sat_hi_unused_s = ^sat_res_s.val[SAT_W-1:OUT_WIDTH];

    // Sequencer: accept, one tap per cycle, round/saturate, hold for consumer.
    always_comb begin
        state_d      = state_q;
        k_d          = k_q;
        mac_load_s   = 1'b0;
        mac_en_s     = 1'b0;
        hist_shift_s = 1'b0;
        hist_clr_s   = 1'b0;
        sat_set_s    = 1'b0;
        dout_d       = dout_q;
        oval_d       = oval_q;
        case (state_q)
            IDLE: begin
                if (flush) begin
                    hist_clr_s = 1'b1;
                end else if (in_valid) begin
                    mac_load_s = 1'b1;
                    k_d        = '0;
                    state_d    = MAC;
                end else begin
                    state_d = IDLE;
                end
            end
            MAC: begin
                mac_en_s = 1'b1;
                if (k_q == KW'(ORDER - 1)) begin
                    k_d     = '0;
                    state_d = ROUND;
                end else begin
                    k_d = k_q + KW'(1);
                end
            end
            ROUND: begin
                dout_d       = sat_val_s;
                hist_shift_s = 1'b1;
                sat_set_s    = sat_res_s.ovf;
                oval_d       = 1'b1;
                state_d      = OUT;
            end
            OUT: begin
                if (out_ready) begin
                    oval_d  = 1'b0;
                    state_d = IDLE;
                end else begin
                    state_d = OUT;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // History next state: clear on flush, shift in the new output, else hold.
    always_comb begin
        hist_d = hist_q;
        if (hist_clr_s) begin
            for (int i = 0; i < ORDER; i++) hist_d[i] = '0;
        end else if (hist_shift_s) begin
            hist_d[0] = sat_val_s;
            for (int i = 1; i < ORDER; i++) hist_d[i] = hist_q[i-1];
        end else begin
            hist_d = hist_q;
        end
    end

    // Sticky saturation flag; a new clip beats a same-cycle clear.
    always_comb begin
        if (sat_set_s) begin
            sat_d = 1'b1;
        end else if (sat_clear) begin
            sat_d = 1'b0;
        end else begin
            sat_d = sat_q;
        end
    end

    // State, counter, history and output registers.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q <= IDLE;
            k_q     <= '0;
            hist_q  <= '{default: '0};
            dout_q  <= '0;
            oval_q  <= 1'b0;
            sat_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            hist_q  <= hist_d;
            dout_q  <= dout_d;
            oval_q  <= oval_d;
            sat_q   <= sat_d;
        end
    end

    assign in_ready  = (state_q == IDLE) && !flush;
    assign out_valid = oval_q;
    assign data_out  = dout_q;
    assign sat_flag  = sat_q;

endmodule
